// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: glitch-filtered clock, frame/parity checking,
// E0/F0 prefix folding and a first-word-fall-through key event FIFO.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned ADDR_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic              key_valid,
    output logic [7:0]        key_code,
    output logic              key_ext,
    output logic              key_release,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

    // Synchronisers, filter and receive state
    logic              clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic              filt_clk_q, filt_clk_d;
    logic [FLT_W-1:0]  flt_cnt_q, flt_cnt_d;
    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [10:0]       shift_q, shift_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              fall, tmo_hit, byte_ok;
    logic              frame_err_q, frame_err_d, parity_err_q, parity_err_d;

    // Prefix flags and pending push
    logic              ext_q, ext_d, brk_q, brk_d;
    logic              push_q, push_d;
    logic [9:0]        push_word_q, push_word_d;

    // FIFO
    logic [9:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              pop, push_ok, drop;
    logic [9:0]        head;

    // Two-flop synchronisers, idle-high after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Glitch filter: follow the synchronised clock only after FILTER_LEN differing samples
    always_comb begin
        filt_clk_d = filt_clk_q;
        flt_cnt_d  = '0;
        if (clk_sync_q != filt_clk_q) begin
            if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_clk_d = clk_sync_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // Data is sampled in the same cycle the filtered clock is registered low
    assign fall    = filt_clk_q & ~filt_clk_d;
    assign tmo_hit = (state_q == StShift) && !fall && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

    // FSM state register and receive datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_clk_q   <= 1'b1;
            flt_cnt_q    <= '0;
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            tmo_cnt_q    <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
        end else begin
            filt_clk_q   <= filt_clk_d;
            flt_cnt_q    <= flt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            tmo_cnt_q    <= tmo_cnt_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            push_q       <= push_d;
            push_word_q  <= push_word_d;
        end
    end

    // FSM next state: shift bits LSB-first, watch for inter-edge timeout
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_cnt_d = tmo_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[10:1]};
                    bit_cnt_d = 4'd1;
                    tmo_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (fall) begin
                    shift_d   = {data_sync_q, shift_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    tmo_cnt_d = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = StCheck;
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StCheck: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: frame checks; shift_q[0]=start, [8:1]=data, [9]=parity, [10]=stop
    always_comb begin
        frame_err_d  = tmo_hit;
        parity_err_d = 1'b0;
        byte_ok      = 1'b0;
        if (state_q == StCheck) begin
            if (shift_q[0] || !shift_q[10]) begin
                frame_err_d = 1'b1;
            end else if (!(^shift_q[9:1])) begin
                parity_err_d = 1'b1;
            end else begin
                byte_ok = 1'b1;
            end
        end
    end

    // Prefix folding: E0/F0 only set flags, other bytes become events
    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        if (frame_err_d || parity_err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q[8:1] == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q[8:1] == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_d      = 1'b1;
                push_word_d = {ext_q, brk_q, shift_q[8:1]};
                ext_d       = 1'b0;
                brk_d       = 1'b0;
            end
        end
    end

    // FIFO control: a pop frees the slot, so a push into a full FIFO with a pop is accepted
    always_comb begin
        pop      = rd_en && (count_q != '0);
        push_ok  = push_q && ((count_q != FULL_CNT) || pop);
        drop     = push_q && (count_q == FULL_CNT) && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end
        // A drop in the same cycle as clr_err keeps the flag set
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO pointer, count and overflow registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage; contents are masked at the outputs while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word_q;
        end
    end

    // Head outputs, forced to zero while empty
    always_comb begin
        head        = mem[rd_ptr_q];
        key_valid   = (count_q != '0);
        key_code    = key_valid ? head[7:0] : 8'h00;
        key_release = key_valid ? head[8] : 1'b0;
        key_ext     = key_valid ? head[9] : 1'b0;
        fifo_count  = count_q;
        overflow    = overflow_q;
        parity_err  = parity_err_q;
        frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder with a scoreboard of expected key events.
module tb_ps2_key_decoder;

    localparam int unsigned TMO  = 1000;
    localparam int unsigned FLT  = 4;
    localparam int unsigned AW   = 3;
    localparam int          HALF = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk, ps2_data, rd_en, clr_err;
    logic        key_valid, key_ext, key_release, overflow, parity_err, frame_err;
    logic [7:0]  key_code;
    logic [AW:0] fifo_count;

    int n_tests = 0;
    int n_fail  = 0;
    int fe_cnt  = 0;
    int pe_cnt  = 0;
    int fe_base, pe_base, k;

    // Expected events: {ext, release, code}
    logic [9:0] exp_q[$];

    ps2_key_decoder #(
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLT),
        .ADDR_W        (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rd_en      (rd_en),
        .clr_err    (clr_err),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_release(key_release),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    // Count error pulse cycles; a correct one-cycle pulse adds exactly one
    always @(posedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one PS/2 frame (or its first nbits bits); optional low glitch during bit 4
    task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit bad_stop,
                              input int nbits, input int glitch);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            tick(HALF);
            if (glitch != 0 && i == 4) begin
                ps2_clk = 1'b0;
                tick(glitch);
                ps2_clk = 1'b1;
                tick(HALF);
            end
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(HALF);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 0);
    endtask

    // Compare the head against the scoreboard front, then pop it
    task automatic pop_check();
        logic [9:0] e;
        e = exp_q.pop_front();
        check("head_code", {24'h0, key_code}, {24'h0, e[7:0]});
        check("head_rel", {31'h0, key_release}, {31'h0, e[8]});
        check("head_ext", {31'h0, key_ext}, {31'h0, e[9]});
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic drain();
        int w;
        while (exp_q.size() > 0) begin
            w = 0;
            while (key_valid !== 1'b1 && w < 100) begin
                tick(1);
                w++;
            end
            if (w >= 100) begin
                check("valid_timeout", 32'd0, 32'd1);
                exp_q.delete();
            end else begin
                pop_check();
            end
        end
        tick(1);
        check("drained_count", {28'h0, fifo_count}, 32'd0);
        check("drained_code", {24'h0, key_code}, 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
        tick(5);
        check("rst_valid", {31'h0, key_valid}, 32'd0);
        check("rst_count", {28'h0, fifo_count}, 32'd0);
        check("rst_ovf", {31'h0, overflow}, 32'd0);
        check("rst_errs", {30'h0, frame_err, parity_err}, 32'd0);
        rst = 1'b1;
        tick(5);

        // Single make code
        key(8'h1C);
        exp_q.push_back({2'b00, 8'h1C});
        tick(5);
        check("one_count", {28'h0, fifo_count}, 32'd1);
        drain();
        rd_en = 1'b1; tick(1); rd_en = 1'b0;
        check("empty_pop", {28'h0, fifo_count}, 32'd0);

        // Break and extended-break sequences
        key(8'hF0); key(8'h1C);
        exp_q.push_back({2'b01, 8'h1C});
        key(8'hE0); key(8'hF0); key(8'h75);
        exp_q.push_back({2'b11, 8'h75});
        tick(5);
        check("prefix_count", {28'h0, fifo_count}, 32'd2);
        drain();

        // Parity error, then a break prefix voided by a bad stop bit
        pe_base = pe_cnt; fe_base = fe_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, 11, 0);
        tick(5);
        check("parity_pulse", pe_cnt - pe_base, 32'd1);
        check("parity_nopush", {28'h0, fifo_count}, 32'd0);
        key(8'hF0);
        send_frame(8'h1C, 1'b0, 1'b1, 11, 0);
        tick(5);
        check("stop_pulse", fe_cnt - fe_base, 32'd1);
        check("stop_nopush", {28'h0, fifo_count}, 32'd0);
        key(8'h1C);
        exp_q.push_back({2'b00, 8'h1C});
        drain();

        // Timeout after 5 bits
        fe_base = fe_cnt;
        send_frame(8'h23, 1'b0, 1'b0, 5, 0);
        tick(TMO + 100);
        check("tmo_pulse", fe_cnt - fe_base, 32'd1);
        key(8'h23);
        exp_q.push_back({2'b00, 8'h23});
        drain();

        // Overflow: nine events, eight fit
        for (int i = 0; i < 9; i++) begin
            key(8'h10 + 8'(i));
            if (i < 8) exp_q.push_back({2'b00, 8'h10 + 8'(i)});
        end
        tick(5);
        check("full_count", {28'h0, fifo_count}, 32'd8);
        check("ovf_set", {31'h0, overflow}, 32'd1);

        // Push into a full FIFO in the same cycle as a pop
        fork
            key(8'h19);
            begin
                k = 0;
                while (dut.push_q !== 1'b1 && k < 2000) begin
                    tick(1);
                    k++;
                end
                check("align_found", {31'h0, k < 2000}, 32'd1);
                pop_check();
            end
        join
        exp_q.push_back({2'b00, 8'h19});
        tick(2);
        check("full_pushpop_count", {28'h0, fifo_count}, 32'd8);
        check("full_pushpop_ovf", {31'h0, overflow}, 32'd1);
        clr_err = 1'b1; tick(1); clr_err = 1'b0;
        check("ovf_clear", {31'h0, overflow}, 32'd0);
        drain();

        // Short clock glitches are filtered out
        send_frame(8'h5A, 1'b0, 1'b0, 11, 1);
        exp_q.push_back({2'b00, 8'h5A});
        send_frame(8'h33, 1'b0, 1'b0, 11, 3);
        exp_q.push_back({2'b00, 8'h33});
        tick(5);
        check("glitch_count", {28'h0, fifo_count}, 32'd2);
        drain();

        // Reset with data queued and a frame in flight
        key(8'hE0); key(8'h44); key(8'h45);
        send_frame(8'h46, 1'b0, 1'b0, 4, 0);
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {31'h0, key_valid}, 32'd0);
        check("mid_rst_count", {28'h0, fifo_count}, 32'd0);
        check("mid_rst_code", {24'h0, key_code}, 32'd0);
        tick(3);
        rst = 1'b1;
        tick(TMO + 100);
        key(8'h29);
        exp_q.push_back({2'b00, 8'h29});
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Parametrised next-generation PS/2 keyboard receiver with scan-code decoding and buffering, running on the 50 MHz master clock domain.
- Receives PS/2 frames through a glitch filter.
- Checks start, stop and odd parity; detects timeouts.
- Folds E0 (extended) and F0 (break) prefixes into the following code.
- Queues decoded key events in a first-word-fall-through FIFO, so the paint control logic can consume at its own pace without losing keys.

Parameters:
- TIMEOUT_CYCLES, 50000: clk cycles allowed between filtered PS/2 falling edges inside a frame.
- FILTER_LEN, 4: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- ADDR_W, 3: FIFO address width; depth = 2**ADDR_W entries.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock line.
- ps2_data  in  1  raw PS/2 data line.
- rd_en  in  1  pop head entry; ignored when key_valid=0.
- clr_err  in  1  clears the sticky overflow flag.
- key_valid  out  1  FIFO non-empty; head fields valid.
- key_code  out  8  head scan code.
- key_ext  out  1  head was preceded by E0.
- key_release  out  1  head was preceded by F0.
- fifo_count  out  ADDR_W+1  entries held.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- parity_err  out  1  one-cycle pulse on a parity failure.
- frame_err  out  1  one-cycle pulse on a bad start/stop bit or a timeout.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FIFO empty, prefix flags clear, FSM in IDLE, filtered clock = 1, synchronisers = 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser.
  - Filtered clock toggles only after FILTER_LEN equal samples that differ from its current level.
  - Falling edge = filtered clock goes 1->0; ps2_data is sampled on that cycle.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: first falling edge shifts the start bit -> SHIFT; bit counter=1; timeout counter=0.
  - SHIFT: each falling edge shifts one bit LSB-first into an 11-bit register and clears the timeout counter. The 11th bit -> CHECK.
  - SHIFT timeout: counter reaching TIMEOUT_CYCLES -> frame_err pulse, prefix flags cleared, -> IDLE, partial frame discarded.
  - CHECK (one cycle):
    - start!=0 or stop!=1 -> frame_err.
    - else XOR of data+parity = 0 -> parity_err.
    - else byte valid.
    - Any error clears the prefix flags. Always -> IDLE.
- Prefix decode (valid byte):
  - E0 sets ext.
  - F0 sets brk.
  - Any other byte pushes {ext,brk,byte} and clears both flags.
  - A prefix never produces an event.
- FIFO:
  - Push occurs in the cycle after CHECK; key_valid rises exactly 2 clk after the cycle registering the 11th falling edge (empty FIFO).
  - FWFT: head fields are stable while key_valid=1.
  - rd_en&key_valid advances head at the next edge.
  - Pointers wrap modulo 2**ADDR_W.
  - Push while full and no pop: event dropped, overflow<=1, count unchanged.
  - Push and pop in the same cycle (including when full): both occur, count unchanged, no overflow.
  - Pop when empty: ignored.
  - clr_err clears overflow; if a drop happens in the same cycle, overflow stays 1 (set wins).
  - Empty FIFO drives key_code/key_ext/key_release = 0.
- Reset mid-frame or with data queued: everything is flushed immediately. The rest of the frame on the wire is parsed from IDLE and typically fails with frame_err or timeout, which is acceptable.

Test Plan:
- Frame 0x1C (parity 0, stop 1) -> key_valid=1, key_code=0x1C, ext=0, release=0, fifo_count=1; rd_en -> count=0.
- Frames F0,1C then E0,F0,75 -> two entries: {0x1C,ext0,rel1}, {0x75,ext1,rel1}; no events for the prefixes.
- Frame 0x1C with parity bit 1 -> parity_err one-cycle pulse, no push. Then F0 followed by a corrupt-stop frame -> frame_err pulse, and the next 0x1C arrives with release=0.
- Stop clock after 5 bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE. Next complete 0x23 frame decodes correctly.
- Push 9 events with ADDR_W=3 and no reads -> count=8, overflow=1, first 8 codes popped in order. A 9th push concurrent with rd_en while full -> accepted, overflow unchanged. clr_err -> overflow=0.
- 1-cycle and 3-cycle glitches on ps2_clk (FILTER_LEN=4) mid-frame -> ignored, byte decodes correctly. Assert rst low mid-frame -> all outputs 0 within the same cycle, FIFO empty.
